// File: rtl/serial_cascade_comparator.sv
// Bit-serial MSB-first magnitude comparator. Streams both operands through a
// 1-bit full-comparator cascade and reports a registered lt/gt/eq verdict.
module serial_cascade_comparator #(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             lt,
    output logic             gt,
    output logic             eq,
    output logic             bit_valid,
    output logic             bit_a,
    output logic             bit_b,
    output logic             lt_cas,
    output logic             gt_cas,
    output logic             eq_cas
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_sh_reg, b_sh_reg;
    logic [CW-1:0]    cnt_reg;
    logic             lt_cas_reg, gt_cas_reg, eq_cas_reg;
    logic             lt_reg, gt_reg, eq_reg;
    logic             lt_cas_next, gt_cas_next, eq_cas_next;
    logic             a_msb, b_msb;

    assign a_msb = a_sh_reg[WIDTH-1];
    assign b_msb = b_sh_reg[WIDTH-1];

    // Once the cascade has decided lt or gt, lower bits cannot change it.
    always_comb begin
        lt_cas_next = lt_cas_reg;
        gt_cas_next = gt_cas_reg;
        eq_cas_next = eq_cas_reg;
        if (eq_cas_reg) begin
            if (a_msb && !b_msb) begin
                lt_cas_next = 1'b0;
                gt_cas_next = 1'b1;
                eq_cas_next = 1'b0;
            end else if (!a_msb && b_msb) begin
                lt_cas_next = 1'b1;
                gt_cas_next = 1'b0;
                eq_cas_next = 1'b0;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) state_next = SHIFT;
            end
            SHIFT: begin
                if (cnt_reg == '0 || (EARLY_EXIT && (lt_cas_next || gt_cas_next)))
                    state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            cnt_reg    <= '0;
            lt_cas_reg <= 1'b0;
            gt_cas_reg <= 1'b0;
            eq_cas_reg <= 1'b1;
            lt_reg     <= 1'b0;
            gt_reg     <= 1'b0;
            eq_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_sh_reg   <= a_in;
                        b_sh_reg   <= b_in;
                        cnt_reg    <= CW'(WIDTH - 1);
                        lt_cas_reg <= 1'b0;
                        gt_cas_reg <= 1'b0;
                        eq_cas_reg <= 1'b1;
                        lt_reg     <= 1'b0;
                        gt_reg     <= 1'b0;
                        eq_reg     <= 1'b0;
                    end
                end
                SHIFT: begin
                    a_sh_reg   <= a_sh_reg << 1;
                    b_sh_reg   <= b_sh_reg << 1;
                    lt_cas_reg <= lt_cas_next;
                    gt_cas_reg <= gt_cas_next;
                    eq_cas_reg <= eq_cas_next;
                    if (cnt_reg != '0) cnt_reg <= cnt_reg - 1'b1;
                    // Verdict is loaded on the way into DONE so it is visible with done.
                    if (state_next == DONE) begin
                        lt_reg <= lt_cas_next;
                        gt_reg <= gt_cas_next;
                        eq_reg <= eq_cas_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state_reg != IDLE);
    assign done      = (state_reg == DONE);
    assign bit_valid = (state_reg == SHIFT);
    assign bit_a     = bit_valid & a_msb;
    assign bit_b     = bit_valid & b_msb;
    assign lt_cas    = lt_cas_reg;
    assign gt_cas    = gt_cas_reg;
    assign eq_cas    = eq_cas_reg;
    assign lt        = lt_reg;
    assign gt        = gt_reg;
    assign eq        = eq_reg;

endmodule

// File: doc/serial_cascade_comparator.md
Name: serial_cascade_comparator

Overview:
- Bit-serial magnitude comparator that drives a 1-bit full-comparator cascade.
- Latches two WIDTH-bit operands and streams them MSB-first, one bit per clock.
- Generates the cascaded less/greater/equal inputs (LtIn/GtIn/EqIn) that each 1-bit stage expects, and folds each bit into a registered cascade state.
- Produces a final Lt/Gt/Eq verdict with a start/busy/done handshake.
- Sits between a control FSM that issues compare requests and any external 1-bit comparator stage connected to the serial tap.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32.
- EARLY_EXIT, 0, 1 = finish as soon as the verdict is decided (Lt or Gt set); 0 = always shift all WIDTH bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  compare request; sampled only in IDLE.
- a_in  input  WIDTH  operand A; latched on the accepted start.
- b_in  input  WIDTH  operand B; latched on the accepted start.
- busy  output  1  high while in SHIFT or DONE.
- done  output  1  one-cycle pulse; verdict valid.
- lt  output  1  registered verdict A<B.
- gt  output  1  registered verdict A>B.
- eq  output  1  registered verdict A==B.
- bit_valid  output  1  high during SHIFT cycles; serial tap valid.
- bit_a  output  1  current bit of A under comparison (MSB first).
- bit_b  output  1  current bit of B under comparison.
- lt_cas  output  1  cascade LtIn for the current bit.
- gt_cas  output  1  cascade GtIn for the current bit.
- eq_cas  output  1  cascade EqIn for the current bit.

Behaviour:
- Reset (rst_n=0, asynchronous, any state): state=IDLE. busy, done, lt, gt, eq, bit_valid, bit_a, bit_b, lt_cas, gt_cas = 0. eq_cas = 1. Shift registers and counter cleared.
- FSM states are IDLE, SHIFT and DONE.
- IDLE:
  - start=1 latches a_in and b_in into shift registers.
  - Sets cascade state (lt_cas,gt_cas,eq_cas) = (0,0,1), bit counter = WIDTH-1, and clears lt/gt/eq to 0.
  - Next state is SHIFT. start=0 stays in IDLE, holding the last verdict.
- SHIFT (one bit per cycle):
  - bit_a and bit_b present the MSB of each shift register; the cascade outputs present the state entering that bit; bit_valid=1.
  - Next cascade state follows 1-bit full-comparator semantics:
    - lt_cas=1 stays (1,0,0); gt_cas=1 stays (0,1,0).
    - eq_cas=1 with A=1,B=0 goes to (0,1,0).
    - eq_cas=1 with A=0,B=1 goes to (1,0,0).
    - eq_cas=1 with equal bits stays (0,0,1).
  - Both shift registers shift left by one; the counter decrements.
  - Leave to DONE after the counter-0 bit. If EARLY_EXIT=1, also leave when the next cascade state has lt or gt set.
- DONE (exactly one cycle):
  - done=1, busy=1, bit_valid=0.
  - lt/gt/eq are loaded from the final cascade state and are visible in this cycle.
  - Next state is IDLE unconditionally. lt/gt/eq hold until the next accepted start.
- Latency with start accepted at edge k:
  - EARLY_EXIT=0: done is high in the cycle after edge k+WIDTH; always WIDTH+1 cycles from accept to done.
  - EARLY_EXIT=1: done follows the first differing bit by one cycle, i.e. (index of the first differing bit from the MSB)+2 cycles. Equal operands still take WIDTH+1 cycles.
- Exactly one of lt/gt/eq is 1 whenever done=1. Between accept and done, all three are 0.
- start while busy (SHIFT or DONE) is ignored, including start coincident with done. No queuing.
- a_in and b_in changes after acceptance have no effect.
- Reset asserted mid-SHIFT aborts the compare immediately. No done pulse is generated; outputs take their reset values.
- The counter is sized clog2(WIDTH) and does not wrap. Exit is decided on counter==0 before the decrement.

Test Plan:
- WIDTH=8, EARLY_EXIT=0, A=0xA5, B=0x5A, start one cycle -> busy for 9 cycles. done in the 9th cycle after accept with gt=1, lt=0, eq=0. gt_cas=1 from the second SHIFT cycle onward.
- A=0x3C, B=0x3C -> eq_cas stays 1 for all 8 bits. done with eq=1. bit_a/bit_b sequence 0,0,1,1,1,1,0,0.
- A=0x00, B=0xFF, EARLY_EXIT=1 -> first bit differs; done 2 cycles after accept with lt=1. A=0x80, B=0x81 with EARLY_EXIT=1 -> 9 cycles, lt=1.
- Compare A=0x10, B=0x20 in progress; pulse start with new operands at cycles 3 and 9 (coincident with done) -> both ignored; verdict lt=1; lt still held 5 cycles later.
- Start A=0xFF, B=0x00; drop rst_n at SHIFT cycle 4 for 1 cycle -> all outputs reset immediately, eq_cas=1, no done pulse. A fresh start then completes normally with gt=1.
- Back-to-back: start asserted the cycle after done -> accepted. lt/gt/eq clear to 0 on accept, then the new verdict appears at done.
